// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side consumer for the async FIFO (rclk domain only).
// Pops show-ahead words from the FIFO and presents them on an m_* valid/ready
// stream through a 2-entry buffer. The head entry is m_data itself.
// Optional: define FIFO_RD_STATS_EN to add pop_count / stall_cycles outputs.
module fifo_rd_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  rempty,
   output logic                  rinc,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [1:0]            cnt
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [15:0]           pop_count,
   output logic [15:0]           stall_cycles
`endif
);

   // The buffer is hard-wired as head + tail registers; reject any other depth.
   generate
      if (BUF_DEPTH != 2) begin : g_bad_depth
         $error("fifo_rd_streamer: BUF_DEPTH must be 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  push, xfer;
   logic [1:0]            cnt_nxt;

   // Pop only when the FIFO has data and the buffer can absorb it this edge;
   // gating with rrst_n keeps rinc low asynchronously during reset.
   assign rinc    = rrst_n & ~rempty & (state == RUN) & ((cnt != 2'd2) | m_ready);
   assign push    = rinc;
   assign m_valid = (cnt != 2'd0);
   assign xfer    = m_valid & m_ready;
   assign cnt_nxt = cnt + {1'b0, push} - {1'b0, xfer};
   assign busy    = (state != IDLE);

   // Occupancy counter.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) cnt <= 2'd0;
      else         cnt <= cnt_nxt;
   end

   // Buffer data path: head (m_data) and tail, kept in FIFO order.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         m_data <= '0;
         tail_q <= '0;
      end else if (push && xfer) begin
         if (cnt == 2'd1) begin
            m_data <= rdata;
         end else begin
            m_data <= tail_q;
            tail_q <= rdata;
         end
      end else if (xfer) begin
         m_data <= tail_q;
      end else if (push) begin
         if (cnt == 2'd0) m_data <= rdata;
         else             tail_q <= rdata;
      end
   end

   // FSM state register.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // FSM next state: DRAIN lets buffered words leave after en drops.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = (cnt_nxt != 2'd0) ? DRAIN : IDLE;
         DRAIN: begin
            if (en)                     state_nxt = RUN;
            else if (cnt_nxt == 2'd0)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FIFO_RD_STATS_EN
   // Pop counter wraps; stall counter saturates.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pop_count    <= 16'd0;
         stall_cycles <= 16'd0;
      end else begin
         if (rinc) pop_count <= pop_count + 16'd1;
         if (m_valid && !m_ready && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule
